// File: rtl/secure_debug_port.sv
// secure_debug_port
//   Authenticated debug access port sitting between the external debug
//   transport and the internal config / status / key storage. Debug reads
//   and writes are gated by a token-unlock FSM with a consecutive-failure
//   counter and a timed lockout. Keys are write-only from debug; only the
//   crypto side reads them, combinationally, through key_rd_idx/key_rd_data.
//
//   Optional build macro: DBG_IDLE_RELOCK_EN
//     When defined, UNLOCKED falls back to LOCKED after IDLE_TIMEOUT idle
//     cycles without a debug request.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   dbg_req/we/addr/wdata   debug access request (one access per req cycle)
//   dbg_ack/rdata/err       registered response, one cycle after each req
//   status_in         live status, returned by reads of STATUS
//   config_out        configuration register
//   key_rd_idx/key_rd_data  crypto-side key read port
//   unlocked          high in UNLOCKED
//   locked_out        high in LOCKOUT
module secure_debug_port #(
   parameter int                DATA_W         = 32,
   parameter int                ADDR_W         = 8,
   parameter int                NUM_KEYS       = 8,
   parameter int                MAX_FAILS      = 3,
   parameter int                LOCKOUT_CYCLES = 1024,
   parameter logic [DATA_W-1:0] AUTH_TOKEN     = DATA_W'(32'hA5C3_0F1E),
   parameter int                IDLE_TIMEOUT   = 4096,
   localparam int               KIW            = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_err,
   input  logic [DATA_W-1:0] status_in,
   output logic [DATA_W-1:0] config_out,
   input  logic [KIW-1:0]    key_rd_idx,
   output logic [DATA_W-1:0] key_rd_data,
   output logic              unlocked,
   output logic              locked_out
);

   localparam int                LCW       = $clog2(LOCKOUT_CYCLES);
   localparam logic [LCW-1:0]    LOCK_LOAD = LCW'(LOCKOUT_CYCLES - 1);
   localparam logic [3:0]        FAIL_LAST = 4'(MAX_FAILS - 1);
   // Key store is rounded up to a power of two so key_rd_idx can index it
   // directly; slots at or above NUM_KEYS are never written and read as 0.
   localparam int                KEY_SLOTS = 1 << KIW;

   localparam logic [ADDR_W-1:0] A_UNLOCK  = ADDR_W'(8'h00);
   localparam logic [ADDR_W-1:0] A_LOCK    = ADDR_W'(8'h01);
   localparam logic [ADDR_W-1:0] A_STAT    = ADDR_W'(8'h02);
   localparam logic [ADDR_W-1:0] A_CFG     = ADDR_W'(8'h10);
   localparam logic [ADDR_W-1:0] A_STS     = ADDR_W'(8'h11);
   localparam logic [ADDR_W-1:0] A_KEY_LO  = ADDR_W'(8'h20);
   localparam logic [ADDR_W-1:0] A_KEY_HI  = ADDR_W'(32 + NUM_KEYS);

   typedef enum logic [1:0] {
      ST_LOCKED,
      ST_UNLOCKED,
      ST_LOCKOUT
   } state_t;

   state_t            state;
   logic [3:0]        fail_cnt;
   logic [LCW-1:0]    lock_cnt;
   logic [DATA_W-1:0] keys [KEY_SLOTS];

`ifdef DBG_IDLE_RELOCK_EN
   localparam int             IW        = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam logic [IW-1:0]  IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
   logic [IW-1:0]             idle_cnt;
`endif

   logic              is_unlock, is_lock, is_stat, is_cfg, is_sts, is_key, tok_ok;
   logic [KIW-1:0]    key_idx;
   logic              err_p0;
   logic [DATA_W-1:0] rdata_p0;

   assign is_unlock = (dbg_addr == A_UNLOCK);
   assign is_lock   = (dbg_addr == A_LOCK);
   assign is_stat   = (dbg_addr == A_STAT);
   assign is_cfg    = (dbg_addr == A_CFG);
   assign is_sts    = (dbg_addr == A_STS);
   assign is_key    = (dbg_addr >= A_KEY_LO) && (dbg_addr < A_KEY_HI);
   assign key_idx   = KIW'(dbg_addr - A_KEY_LO);
   assign tok_ok    = (dbg_wdata == AUTH_TOKEN);

   assign key_rd_data = keys[key_rd_idx];

   // ---- stage p0: access decode against the current state ----
   // rdata_p0 stays zero for every rejected access and for all writes.
   always_comb begin
      err_p0   = 1'b1;
      rdata_p0 = '0;
      if (!dbg_we && is_stat) begin
         err_p0   = 1'b0;
         rdata_p0 = DATA_W'({locked_out, unlocked, fail_cnt});
      end else begin
         case (state)
            ST_LOCKED: begin
               if (dbg_we && is_unlock && tok_ok) err_p0 = 1'b0;
            end
            ST_UNLOCKED: begin
               if (dbg_we) begin
                  err_p0 = !(is_unlock || is_lock || is_cfg || is_key);
               end else if (is_cfg) begin
                  err_p0   = 1'b0;
                  rdata_p0 = config_out;
               end else if (is_sts) begin
                  err_p0   = 1'b0;
                  rdata_p0 = status_in;
               end
            end
            default: ;
         endcase
      end
   end

   // ---- stage p1: registered response, FSM and storage update ----
   // unlocked/locked_out are written together with state so the ack of a
   // transitioning access already shows the new state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_LOCKED;
         fail_cnt   <= '0;
         lock_cnt   <= '0;
         config_out <= '0;
         for (int i = 0; i < KEY_SLOTS; i++) keys[i] <= '0;
         dbg_ack    <= 1'b0;
         dbg_rdata  <= '0;
         dbg_err    <= 1'b0;
         unlocked   <= 1'b0;
         locked_out <= 1'b0;
`ifdef DBG_IDLE_RELOCK_EN
         idle_cnt   <= '0;
`endif
      end else begin
         dbg_ack   <= dbg_req;
         dbg_err   <= dbg_req & err_p0;
         dbg_rdata <= dbg_req ? rdata_p0 : '0;
`ifdef DBG_IDLE_RELOCK_EN
         idle_cnt  <= '0;
`endif
         case (state)
            ST_LOCKED: begin
               if (dbg_req && dbg_we && is_unlock) begin
                  if (tok_ok) begin
                     state    <= ST_UNLOCKED;
                     unlocked <= 1'b1;
                     fail_cnt <= '0;
                  end else if (fail_cnt == FAIL_LAST) begin
                     state      <= ST_LOCKOUT;
                     locked_out <= 1'b1;
                     lock_cnt   <= LOCK_LOAD;
                     fail_cnt   <= '0;
                  end else begin
                     fail_cnt <= fail_cnt + 4'd1;
                  end
               end
            end
            ST_UNLOCKED: begin
               if (dbg_req && dbg_we) begin
                  if (is_cfg) config_out <= dbg_wdata;
                  if (is_key) keys[key_idx] <= dbg_wdata;
                  if (is_lock) begin
                     state    <= ST_LOCKED;
                     unlocked <= 1'b0;
                  end
               end
`ifdef DBG_IDLE_RELOCK_EN
               // A request in the timeout cycle keeps the port unlocked.
               if (!dbg_req) begin
                  if (idle_cnt == IDLE_LAST) begin
                     state    <= ST_LOCKED;
                     unlocked <= 1'b0;
                  end else begin
                     idle_cnt <= idle_cnt + IW'(1);
                  end
               end
`endif
            end
            ST_LOCKOUT: begin
               if (lock_cnt == '0) begin
                  state      <= ST_LOCKED;
                  locked_out <= 1'b0;
               end else begin
                  lock_cnt <= lock_cnt - LCW'(1);
               end
            end
            default: begin
               state      <= ST_LOCKED;
               unlocked   <= 1'b0;
               locked_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_secure_debug_port.sv
// Testbench for secure_debug_port: directed steps from one initial block,
// expected responses queued at drive time and compared when the ack appears.
module tb_secure_debug_port;

   localparam logic [31:0] TOKEN = 32'hA5C3_0F1E;

   logic        clk = 1'b0;
   logic        rst;
   logic        dbg_req;
   logic        dbg_we;
   logic [7:0]  dbg_addr;
   logic [31:0] dbg_wdata;
   logic        dbg_ack;
   logic [31:0] dbg_rdata;
   logic        dbg_err;
   logic [31:0] status_in;
   logic [31:0] config_out;
   logic [2:0]  key_rd_idx;
   logic [31:0] key_rd_data;
   logic        unlocked;
   logic        locked_out;

   secure_debug_port #(
      .IDLE_TIMEOUT (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .dbg_req     (dbg_req),
      .dbg_we      (dbg_we),
      .dbg_addr    (dbg_addr),
      .dbg_wdata   (dbg_wdata),
      .dbg_ack     (dbg_ack),
      .dbg_rdata   (dbg_rdata),
      .dbg_err     (dbg_err),
      .status_in   (status_in),
      .config_out  (config_out),
      .key_rd_idx  (key_rd_idx),
      .key_rd_data (key_rd_data),
      .unlocked    (unlocked),
      .locked_out  (locked_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] rdata;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   ce;
   int   u;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Response monitor: an ack must appear exactly in the cycle an entry is
   // due, and never otherwise.
   always @(negedge clk) begin
      exp_t x;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         x = sb.pop_front();
         chk({x.tag, " ack"},   32'(dbg_ack), 32'd1);
         chk({x.tag, " err"},   32'(dbg_err), 32'(x.err));
         chk({x.tag, " rdata"}, dbg_rdata,    x.rdata);
      end else begin
         chk("no_ack", 32'(dbg_ack), 32'd0);
      end
   end

   // Drives one access at a negedge, queues its expected response, and
   // returns at the negedge right after the sampling edge.
   task automatic acc(input string tag, input logic we, input logic [7:0] addr,
                      input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd);
      exp_t x;
      dbg_req   = 1'b1;
      dbg_we    = we;
      dbg_addr  = addr;
      dbg_wdata = wd;
      x.due   = cyc + 1;
      x.err   = e_err;
      x.rdata = e_rd;
      x.tag   = tag;
      sb.push_back(x);
      @(posedge clk);
      #1 dbg_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      dbg_req    = 1'b0;
      dbg_we     = 1'b0;
      dbg_addr   = '0;
      dbg_wdata  = '0;
      status_in  = 32'hDEAD_BEEF;
      key_rd_idx = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst unlocked",   32'(unlocked),   32'd0);
      chk("rst locked_out", 32'(locked_out), 32'd0);
      chk("rst config",     config_out,      32'd0);
      chk("rst key0",       key_rd_data,     32'd0);
      chk("rst rdata",      dbg_rdata,       32'd0);
      chk("rst err",        32'(dbg_err),    32'd0);

      // Locked: only AUTH_STAT reads and UNLOCK writes pass
      acc("lk rd cfg",  1'b0, 8'h10, 32'h0,         1'b1, 32'h0);
      acc("lk rd stat", 1'b0, 8'h02, 32'h0,         1'b0, 32'h0);
      acc("lk wr cfg",  1'b1, 8'h10, 32'hFFFF_FFFF, 1'b1, 32'h0);
      acc("lk wr key",  1'b1, 8'h20, 32'h1111_1111, 1'b1, 32'h0);
      acc("lk wr lock", 1'b1, 8'h01, 32'h0,         1'b1, 32'h0);
      chk("lk cfg untouched", config_out,  32'd0);
      chk("lk key untouched", key_rd_data, 32'd0);

      // Unlock and exercise the register map
      acc("unlock", 1'b1, 8'h00, TOKEN, 1'b0, 32'h0);
      chk("unlock state", 32'(unlocked), 32'd1);
      acc("wr cfg", 1'b1, 8'h10, 32'h1234_5678, 1'b0, 32'h0);
      acc("rd cfg", 1'b0, 8'h10, 32'h0,         1'b0, 32'h1234_5678);
      chk("config_out", config_out, 32'h1234_5678);
      acc("ul rd stat",   1'b0, 8'h02, 32'h0, 1'b0, 32'h0000_0010);
      acc("rd status",    1'b0, 8'h11, 32'h0, 1'b0, 32'hDEAD_BEEF);
      acc("wr status",    1'b1, 8'h11, 32'h5, 1'b1, 32'h0);
      acc("wr stat",      1'b1, 8'h02, 32'h5, 1'b1, 32'h0);
      acc("rd unlock",    1'b0, 8'h00, 32'h0, 1'b1, 32'h0);
      acc("rd lock",      1'b0, 8'h01, 32'h0, 1'b1, 32'h0);
      acc("rd unmapped",  1'b0, 8'h05, 32'h0, 1'b1, 32'h0);
      acc("wr past keys", 1'b1, 8'h28, 32'h9, 1'b1, 32'h0);
      acc("re-unlock",    1'b1, 8'h00, 32'h0, 1'b0, 32'h0);
      chk("re-unlock state", 32'(unlocked), 32'd1);

      // Key store: write-only from debug, readable on the crypto port
      acc("wr key3", 1'b1, 8'h23, 32'hCAFE_F00D, 1'b0, 32'h0);
      key_rd_idx = 3'd3;
      #1 chk("key3 rd port", key_rd_data, 32'hCAFE_F00D);
      acc("wr key7", 1'b1, 8'h27, 32'h7777_7777, 1'b0, 32'h0);
      key_rd_idx = 3'd7;
      #1 chk("key7 rd port", key_rd_data, 32'h7777_7777);
      acc("rd key3", 1'b0, 8'h23, 32'h0, 1'b1, 32'h0);

      // Back-to-back: LOCK then CONFIG read on the very next cycle
      acc("b2b lock",   1'b1, 8'h01, 32'h0, 1'b0, 32'h0);
      acc("b2b rd cfg", 1'b0, 8'h10, 32'h0, 1'b1, 32'h0);
      chk("b2b relocked", 32'(unlocked), 32'd0);

      // Failed attempts and lockout
      acc("bad1",       1'b1, 8'h00, 32'h0, 1'b1, 32'h0);
      acc("stat fail1", 1'b0, 8'h02, 32'h0, 1'b0, 32'h0000_0001);
      acc("bad2",       1'b1, 8'h00, 32'h0, 1'b1, 32'h0);
      acc("stat fail2", 1'b0, 8'h02, 32'h0, 1'b0, 32'h0000_0002);
      acc("bad3",       1'b1, 8'h00, 32'h0, 1'b1, 32'h0);
      ce = cyc;
      chk("lockout entered", 32'(locked_out), 32'd1);
      chk("lockout unlocked", 32'(unlocked),  32'd0);
      acc("lo stat",   1'b0, 8'h02, 32'h0, 1'b0, 32'h0000_0020);
      acc("lo token",  1'b1, 8'h00, TOKEN, 1'b1, 32'h0);
      acc("lo rd cfg", 1'b0, 8'h10, 32'h0, 1'b1, 32'h0);
      chk("lo token ignored", 32'(unlocked), 32'd0);
      wait_until(ce + 1022);
      acc("lo last token", 1'b1, 8'h00, TOKEN, 1'b1, 32'h0);
      chk("lo last cycle", 32'(locked_out), 32'd1);
      @(negedge clk);
      chk("lo expired",       32'(locked_out), 32'd0);
      chk("lo expired state", 32'(unlocked),   32'd0);
      acc("post lo stat",   1'b0, 8'h02, 32'h0, 1'b0, 32'h0);
      acc("post lo unlock", 1'b1, 8'h00, TOKEN, 1'b0, 32'h0);
      chk("post lo unlocked", 32'(unlocked), 32'd1);

      // Reset in the middle of traffic
      acc("pre-rst wr cfg", 1'b1, 8'h10, 32'h55AA_55AA, 1'b0, 32'h0);
      chk("pre-rst config", config_out, 32'h55AA_55AA);
      dbg_req  = 1'b1;
      dbg_we   = 1'b0;
      dbg_addr = 8'h10;
      rst      = 1'b1;
      @(posedge clk);
      #1 dbg_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("rst mid ack",    32'(dbg_ack),  32'd0);
      chk("rst mid config", config_out,    32'd0);
      chk("rst mid state",  32'(unlocked), 32'd0);
      key_rd_idx = 3'd3;
      #1 chk("rst mid key3", key_rd_data, 32'd0);
      acc("rst mid stat", 1'b0, 8'h02, 32'h0, 1'b0, 32'h0);

`ifdef DBG_IDLE_RELOCK_EN
      // Idle relock after 16 quiet cycles
      acc("idle unlock", 1'b1, 8'h00, TOKEN, 1'b0, 32'h0);
      u = cyc;
      wait_until(u + 15);
      chk("idle before timeout", 32'(unlocked), 32'd1);
      @(negedge clk);
      chk("idle relocked", 32'(unlocked), 32'd0);
      // Request in the timeout cycle keeps the port unlocked
      acc("idle unlock2", 1'b1, 8'h00, TOKEN, 1'b0, 32'h0);
      u = cyc;
      wait_until(u + 15);
      acc("idle req15", 1'b0, 8'h02, 32'h0, 1'b0, 32'h0000_0010);
      chk("idle req wins", 32'(unlocked), 32'd1);
      repeat (8) @(negedge clk);
      chk("idle still unlocked", 32'(unlocked), 32'd1);
`endif

      repeat (2) @(negedge clk);
      chk("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
